clk_div_prog: RTL

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog -- programmable integer clock divider with glitch-free divisor
// reload.
//
// A counter runs 0..D-1 and wraps, so one clk_out period is exactly D clk
// periods for any D in 2..2^W-1. clk_out and tick are registered: both rise
// on the posedge where the counter becomes 0, and tick lasts one clk cycle.
//
// A new divisor is captured into a shadow register by a div_load strobe and
// only moves into div_cur at a period boundary, so a period is never cut
// short or stretched. Clearing en lets the current period finish, then parks
// the counter at D-1 with clk_out low until en returns.
//
// Optional feature (macro CLK_DIV_PROG_DUTY50_EN):
//   defined   -> a negedge register trims the last high cycle by half a clk
//                period, giving exactly 50% duty for odd D.
//   undefined -> posedge logic only; clk_out is high floor(D/2) cycles and
//                low ceil(D/2) cycles. Period and tick timing are identical.
//
// Parameters:
//   W        width of the divisor and counter
//   DEF_DIV  divisor in effect after reset (2..2^W-1)
//
// Ports:
//   clk       input clock
//   rst       synchronous active-high reset (priority over en and div_load)
//   en        run enable
//   div_val   requested divisor; 0 and 1 are clamped to 2 on capture
//   div_load  single-cycle strobe capturing div_val into the shadow register
//   clk_out   divided clock
//   tick      one-cycle pulse marking each clk_out rising edge
//   div_cur   divisor currently in effect
//   pend      high while a captured divisor waits for its period boundary
// -----------------------------------------------------------------------------
module clk_div_prog #(
  parameter int W       = 8,
  parameter int DEF_DIV = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_val,
  input  logic         div_load,
  output logic         clk_out,
  output logic         tick,
  output logic [W-1:0] div_cur,
  output logic         pend
);

  localparam logic [W-1:0] DEF_D = W'(DEF_DIV);
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] TWO   = W'(2);

  logic [W-1:0] cnt;
  logic [W-1:0] shadow;
  logic         phase_q;   // posedge-generated high phase of clk_out

  logic [W-1:0] load_val;
  logic         at_end;    // counter sits on the last cycle of the period
  logic         wrap;      // period boundary where the counter restarts at 0
  logic [W-1:0] d_next;
  logic [W-1:0] cnt_next;
  logic [W:0]   d_ext;
  logic [W:0]   hi_len;    // number of posedge cycles phase_q stays high
  logic         phase_next;

  always_comb begin
    load_val   = (div_val < TWO) ? TWO : div_val;
    at_end     = (cnt >= div_cur - ONE);
    wrap       = at_end & en;
    // The shadow moves in at any boundary, including the parked one while
    // en is low, so the held counter always reflects the divisor in effect.
    d_next     = (at_end && pend) ? shadow : div_cur;
    if (!at_end) begin
      cnt_next = cnt + ONE;
    end else if (en) begin
      cnt_next = '0;
    end else begin
      cnt_next = d_next - ONE;
    end
    d_ext      = {1'b0, d_next};
`ifdef CLK_DIV_PROG_DUTY50_EN
    // Odd D: stay high ceil(D/2) cycles; the negedge mask removes the last
    // half cycle.
    hi_len     = (d_ext + {{W{1'b0}}, 1'b1}) >> 1;
`else
    hi_len     = d_ext >> 1;
`endif
    // Parked at D-1 this is always 0, so clk_out holds low while disabled.
    phase_next = ({1'b0, cnt_next} < hi_len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= DEF_D - ONE;
      div_cur <= DEF_D;
      shadow  <= DEF_D;
      pend    <= 1'b0;
      phase_q <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      div_cur <= d_next;
      phase_q <= phase_next;
      tick    <= wrap;
      // A load on the boundary edge itself lands in the shadow after the
      // old shadow has moved into div_cur, so it waits for the next boundary.
      if (div_load) begin
        shadow <= load_val;
        pend   <= 1'b1;
      end else if (at_end && pend) begin
        pend   <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_PROG_DUTY50_EN
  logic keep_q;  // low during the last high cycle of an odd period
  logic neg_q;   // keep_q re-timed to the falling edge of clk

  always_ff @(posedge clk) begin
    if (rst) begin
      keep_q <= 1'b1;
    end else begin
      keep_q <= ~(d_next[0] && (cnt_next == (d_next >> 1)));
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= keep_q;
    end
  end

  assign clk_out = phase_q & neg_q;
`else
  assign clk_out = phase_q;
`endif

endmodule
